// File: rtl/port_dispatch_sched.sv
// ============================================================================
// port_dispatch_sched : in-order descriptor dispatcher to three read ports
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module port_dispatch_sched #(
    parameter int UWIDTH     = 8,
    parameter int PTR_SZ     = 2,
    parameter int PTR_IN_SZ  = 4,
    parameter int DEST_FIELD = 1,
    parameter int PORT2_LO   = 128,
    parameter int PORT3_LO   = 196
) (
    input  logic                 clk2,
    input  logic                 rst,
    input  logic                 desc_valid,
    input  logic [PTR_SZ-1:0]    desc_idx,
    output logic                 desc_ready,
    output logic                 uread_en,
    output logic [PTR_SZ-1:0]    uaddr,
    output logic [PTR_IN_SZ-1:0] uaddr_in,
    input  logic [UWIDTH-1:0]    udata,
    output logic                 read_port_1_en,
    output logic                 read_port_2_en,
    output logic                 read_port_3_en,
    output logic [PTR_SZ-1:0]    raddr_port_1,
    output logic [PTR_SZ-1:0]    raddr_port_2,
    output logic [PTR_SZ-1:0]    raddr_port_3,
    input  logic                 read_port_1_done,
    input  logic                 read_port_2_done,
    input  logic                 read_port_3_done,
    output logic                 free_valid,
    output logic [PTR_SZ-1:0]    free_idx,
    input  logic                 free_ready,
    output logic [1:0]           active_ports
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        CLASSIFY = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t              state_q;
    logic [1:0]          port_q;
    logic [3:1]          en_q, en_d;
    logic [3:1]          pend_q, pend_d;
    logic [3:1]          cap_w, served_w, issue_oh_w;
    logic [PTR_SZ-1:0]   raddr_q   [1:3];
    logic [PTR_SZ-1:0]   ret_idx_q [1:3];
    logic [PTR_SZ-1:0]   ret_idx_d [1:3];
    logic [1:0]          ptr_q, ptr_d, sel_q, sel_d, cand_w;
    logic [1:0]          dest_port_w, issue_port_w;
    logic                issue_w, frozen_w, accept_w, found_w;
    logic                free_valid_q;
    logic [PTR_SZ-1:0]   free_idx_q, free_idx_d;
    logic                desc_ready_q, uread_en_q;
    logic [PTR_SZ-1:0]   uaddr_q;
    logic [PTR_IN_SZ-1:0] uaddr_in_q;
    logic [1:0]          active_q, active_d;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd3) ? 2'd1 : p + 2'd1;
    endfunction

    always_comb begin
        if (udata >= UWIDTH'(PORT3_LO))
            dest_port_w = 2'd3;
        else if (udata >= UWIDTH'(PORT2_LO))
            dest_port_w = 2'd2;
        else
            dest_port_w = 2'd1;
    end

    always_comb begin
        cap_w    = {read_port_3_done, read_port_2_done, read_port_1_done} & en_q;
        frozen_w = free_valid_q & ~free_ready;
        accept_w = free_valid_q & free_ready;
        served_w = '0;
        if (accept_w)
            served_w[sel_q] = 1'b1;
        pend_d = (pend_q & ~served_w) | cap_w;
        ptr_d  = accept_w ? next_port(sel_q) : ptr_q;

        // Availability looks only at registered state: a same-cycle done does not count.
        issue_port_w = (state_q == CLASSIFY) ? dest_port_w : port_q;
        issue_w      = ((state_q == CLASSIFY) || (state_q == HOLD)) &&
                       !en_q[issue_port_w] && !pend_q[issue_port_w];
        issue_oh_w = '0;
        if (issue_w)
            issue_oh_w[issue_port_w] = 1'b1;
        en_d     = (en_q & ~cap_w) | issue_oh_w;
        active_d = {1'b0, en_d[1]} + {1'b0, en_d[2]} + {1'b0, en_d[3]};

        for (int p = 1; p <= 3; p++)
            ret_idx_d[p] = cap_w[p] ? raddr_q[p] : ret_idx_q[p];

        sel_d      = sel_q;
        free_idx_d = free_idx_q;
        cand_w     = ptr_d;
        found_w    = 1'b0;
        if (!frozen_w) begin
            sel_d = ptr_d;
            for (int k = 0; k < 3; k++) begin
                if (!found_w && pend_d[cand_w]) begin
                    sel_d   = cand_w;
                    found_w = 1'b1;
                end
                cand_w = next_port(cand_w);
            end
            free_idx_d = found_w ? ret_idx_d[sel_d] : '0;
        end
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            port_q       <= 2'd1;
            en_q         <= '0;
            pend_q       <= '0;
            ptr_q        <= 2'd1;
            sel_q        <= 2'd1;
            free_valid_q <= 1'b0;
            free_idx_q   <= '0;
            desc_ready_q <= 1'b0;
            uread_en_q   <= 1'b0;
            uaddr_q      <= '0;
            uaddr_in_q   <= '0;
            active_q     <= '0;
            for (int p = 1; p <= 3; p++) begin
                raddr_q[p]   <= '0;
                ret_idx_q[p] <= '0;
            end
        end else begin
            en_q         <= en_d;
            pend_q       <= pend_d;
            ptr_q        <= ptr_d;
            sel_q        <= sel_d;
            free_valid_q <= |pend_d;
            free_idx_q   <= free_idx_d;
            active_q     <= active_d;
            desc_ready_q <= issue_w;
            uread_en_q   <= 1'b0;
            for (int p = 1; p <= 3; p++) begin
                ret_idx_q[p] <= ret_idx_d[p];
                if (issue_oh_w[p])
                    raddr_q[p] <= uaddr_q;
            end
            case (state_q)
                // The head is still the just-popped entry while desc_ready is high.
                IDLE: begin
                    if (desc_valid && !desc_ready_q) begin
                        state_q    <= FETCH;
                        uread_en_q <= 1'b1;
                        uaddr_q    <= desc_idx;
                        uaddr_in_q <= PTR_IN_SZ'(DEST_FIELD);
                    end
                end
                FETCH: state_q <= CLASSIFY;
                CLASSIFY: begin
                    port_q  <= dest_port_w;
                    state_q <= issue_w ? IDLE : HOLD;
                end
                HOLD: begin
                    if (issue_w)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign desc_ready     = desc_ready_q;
    assign uread_en       = uread_en_q;
    assign uaddr          = uaddr_q;
    assign uaddr_in       = uaddr_in_q;
    assign read_port_1_en = en_q[1];
    assign read_port_2_en = en_q[2];
    assign read_port_3_en = en_q[3];
    assign raddr_port_1   = raddr_q[1];
    assign raddr_port_2   = raddr_q[2];
    assign raddr_port_3   = raddr_q[3];
    assign free_valid     = free_valid_q;
    assign free_idx       = free_idx_q;
    assign active_ports   = active_q;

endmodule

`default_nettype wire

// File: tb/tb_port_dispatch_sched.sv
// ============================================================================
// tb_port_dispatch_sched : directed + randomized bench with a behavioural model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_port_dispatch_sched;

    localparam int C_DEST = 1;

    logic       clk2 = 1'b0;
    logic       rst;
    logic       desc_valid;
    logic [1:0] desc_idx;
    logic       desc_ready;
    logic       uread_en;
    logic [1:0] uaddr;
    logic [3:0] uaddr_in;
    logic [7:0] udata;
    logic       read_port_1_en, read_port_2_en, read_port_3_en;
    logic [1:0] raddr_port_1, raddr_port_2, raddr_port_3;
    logic       read_port_1_done, read_port_2_done, read_port_3_done;
    logic       free_valid;
    logic [1:0] free_idx;
    logic       free_ready;
    logic [1:0] active_ports;

    port_dispatch_sched dut (
        .clk2(clk2), .rst(rst),
        .desc_valid(desc_valid), .desc_idx(desc_idx), .desc_ready(desc_ready),
        .uread_en(uread_en), .uaddr(uaddr), .uaddr_in(uaddr_in), .udata(udata),
        .read_port_1_en(read_port_1_en), .read_port_2_en(read_port_2_en),
        .read_port_3_en(read_port_3_en),
        .raddr_port_1(raddr_port_1), .raddr_port_2(raddr_port_2),
        .raddr_port_3(raddr_port_3),
        .read_port_1_done(read_port_1_done), .read_port_2_done(read_port_2_done),
        .read_port_3_done(read_port_3_done),
        .free_valid(free_valid), .free_idx(free_idx), .free_ready(free_ready),
        .active_ports(active_ports)
    );

    always #5 clk2 = ~clk2;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // Environment: payload memory and descriptor queue
    logic [7:0] mem [0:3][0:15];
    int         q[$];
    bit         auto_mode = 0;
    bit         chk_on = 0;
    bit         s_dr, s_ure;
    logic [1:0] s_ua;
    logic [3:0] s_uin;

    // Behavioural model
    int         m_t, m_port, m_sel, m_ptr;
    logic [3:1] m_en, m_pend;
    logic [1:0] m_raddr  [1:3];
    logic [1:0] m_retidx [1:3];
    logic [1:0] m_ua, m_fidx;
    bit         m_dr, m_ure, m_fv;

    function automatic int dest_to_port(input int d);
        if (d < 128) return 1;
        if (d < 196) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_t = 0; m_port = 1; m_sel = 1; m_ptr = 1;
        m_en = '0; m_pend = '0; m_ua = '0; m_fidx = '0;
        m_dr = 0; m_ure = 0; m_fv = 0;
        for (int p = 1; p <= 3; p++) begin
            m_raddr[p] = '0; m_retidx[p] = '0;
        end
    endtask

    task automatic model_step();
        logic [3:1] cap;
        int  served, issue_p;
        bit  frozen, prev_dr;
        if (rst) begin
            model_reset();
            return;
        end
        cap     = {read_port_3_done, read_port_2_done, read_port_1_done} & m_en;
        frozen  = m_fv && !free_ready;
        served  = (m_fv && free_ready) ? m_sel : 0;
        prev_dr = m_dr;
        m_dr    = 0;
        m_ure   = 0;
        issue_p = 0;
        if (m_t == 0) begin
            if (desc_valid && !prev_dr) begin
                m_t = 1; m_ure = 1; m_ua = desc_idx;
            end
        end else if (m_t == 1) begin
            m_t = 2;
        end else begin
            if (m_t == 2) m_port = dest_to_port(int'(mem[m_ua][C_DEST]));
            if (!m_en[m_port] && !m_pend[m_port]) begin
                issue_p = m_port; m_t = 0; m_dr = 1;
            end else begin
                m_t = 3;
            end
        end
        for (int p = 1; p <= 3; p++)
            if (cap[p]) m_retidx[p] = m_raddr[p];
        m_en = m_en & ~cap;
        if (issue_p != 0) begin
            m_en[issue_p] = 1'b1;
            m_raddr[issue_p] = m_ua;
        end
        if (served != 0) begin
            m_pend[served] = 1'b0;
            m_ptr = served % 3 + 1;
        end
        m_pend = m_pend | cap;
        m_fv = |m_pend;
        if (!frozen && m_fv) begin
            for (int k = 0; k < 3; k++) begin
                int c;
                c = (m_ptr - 1 + k) % 3 + 1;
                if (m_pend[c]) begin
                    m_sel = c;
                    break;
                end
            end
            m_fidx = m_retidx[m_sel];
        end
    endtask

    always @(negedge clk2) begin
        s_dr = desc_ready; s_ure = uread_en; s_ua = uaddr; s_uin = uaddr_in;
        if (chk_on && !rst) begin
            chk("m_desc_ready", desc_ready, m_dr);
            chk("m_uread_en", uread_en, m_ure);
            if (m_ure) begin
                chk("m_uaddr", uaddr, m_ua);
                chk("m_uaddr_in", uaddr_in, C_DEST);
            end
            chk("m_en", {read_port_3_en, read_port_2_en, read_port_1_en}, m_en);
            chk("m_raddr1", raddr_port_1, m_raddr[1]);
            chk("m_raddr2", raddr_port_2, m_raddr[2]);
            chk("m_raddr3", raddr_port_3, m_raddr[3]);
            chk("m_free_valid", free_valid, m_fv);
            if (m_fv) chk("m_free_idx", free_idx, m_fidx);
            chk("m_active", active_ports, m_en[1] + m_en[2] + m_en[3]);
        end
    end

    task automatic refresh();
        desc_valid = (q.size() > 0);
        desc_idx   = desc_valid ? 2'(q[0]) : 2'd0;
    endtask

    task automatic push(input int idx);
        q.push_back(idx);
        refresh();
    endtask

    task automatic tick();
        @(posedge clk2);
        model_step();
        #1;
        if (s_dr && q.size() > 0) q.delete(0);
        udata = s_ure ? mem[s_ua][s_uin] : 8'($urandom);
        refresh();
        read_port_1_done = 0; read_port_2_done = 0; read_port_3_done = 0;
        if (auto_mode) begin
            read_port_1_done = read_port_1_en ? ($urandom % 4 == 0) : ($urandom % 10 == 0);
            read_port_2_done = read_port_2_en ? ($urandom % 4 == 0) : ($urandom % 10 == 0);
            read_port_3_done = read_port_3_en ? ($urandom % 4 == 0) : ($urandom % 10 == 0);
            free_ready = ($urandom % 4 != 0);
            if (q.size() < 3 && $urandom % 5 == 0) push(int'($urandom % 4));
        end
    endtask

    task automatic set_dest(input int s, input int d);
        mem[s][C_DEST] = 8'(d);
    endtask

    function automatic int pick_dest();
        case ($urandom % 8)
            0: return 127;
            1: return 128;
            2: return 195;
            3: return 196;
            4: return 255;
            5: return 0;
            default: return int'($urandom % 256);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; desc_valid = 0; desc_idx = 0; udata = 0; free_ready = 0;
        read_port_1_done = 0; read_port_2_done = 0; read_port_3_done = 0;
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 16; w++)
                mem[s][w] = 8'($urandom);
        model_reset();
        repeat (3) tick();
        chk("reset_outputs", {desc_ready, uread_en, uaddr, uaddr_in, read_port_1_en,
            read_port_2_en, read_port_3_en, raddr_port_1, raddr_port_2, raddr_port_3,
            free_valid, free_idx, active_ports}, 0);
        rst = 0;
        chk_on = 1;

        // Single dispatch: slot 2, dest 100 -> port 1 at cycle 3
        set_dest(2, 100);
        push(2);
        tick(); tick(); tick();
        chk("single_en1", read_port_1_en, 1);
        chk("single_raddr1", raddr_port_1, 2);
        chk("single_desc_ready", desc_ready, 1);
        tick();
        read_port_1_done = 1;
        tick();
        chk("single_en1_clr", read_port_1_en, 0);
        chk("single_free_valid", free_valid, 1);
        chk("single_free_idx", free_idx, 2);
        free_ready = 1;
        tick();
        chk("single_free_drained", free_valid, 0);

        // Classification boundaries and three concurrent ports
        set_dest(0, 127); set_dest(1, 128); set_dest(3, 196);
        push(0); push(1); push(3);
        repeat (14) tick();
        chk("bnd_enables", {read_port_3_en, read_port_2_en, read_port_1_en}, 3'b111);
        chk("bnd_active3", active_ports, 3);
        chk("bnd_127_port1", raddr_port_1, 0);
        chk("bnd_128_port2", raddr_port_2, 1);
        chk("bnd_196_port3", raddr_port_3, 3);
        read_port_1_done = 1; read_port_2_done = 1; read_port_3_done = 1;
        tick();
        chk("rr_first", free_idx, 1);
        tick();
        chk("rr_second", free_idx, 3);
        tick();
        chk("rr_third", free_idx, 0);
        tick();
        chk("rr_empty", free_valid, 0);
        set_dest(2, 195); set_dest(0, 255);
        push(2); push(0);
        repeat (10) tick();
        chk("bnd_195_port2", {read_port_2_en, raddr_port_2}, {1'b1, 2'd2});
        chk("bnd_255_port3", {read_port_3_en, raddr_port_3}, {1'b1, 2'd0});
        read_port_2_done = 1; read_port_3_done = 1;
        repeat (4) tick();

        // Head-of-line blocking on port 2
        free_ready = 0;
        set_dest(0, 150); set_dest(1, 150);
        push(0); push(1);
        repeat (4) tick();
        chk("hol_en2", {read_port_2_en, raddr_port_2}, {1'b1, 2'd0});
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("hol_no_pop", desc_ready, 0);
        end
        read_port_2_done = 1;
        tick();
        chk("hol_done_free", {read_port_2_en, free_valid, free_idx}, {1'b0, 1'b1, 2'd0});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hol_frozen", {read_port_2_en, free_valid, free_idx}, {1'b0, 1'b1, 2'd0});
        end
        free_ready = 1;
        tick();
        chk("hol_returned", {free_valid, read_port_2_en}, 2'b00);
        tick();
        chk("hol_issue", {read_port_2_en, raddr_port_2, desc_ready}, {1'b1, 2'd1, 1'b1});
        tick();
        read_port_2_done = 1;
        repeat (3) tick();

        // Asynchronous reset while holding behind a busy port 1
        set_dest(0, 10); set_dest(1, 20);
        push(0); push(1);
        repeat (8) tick();
        chk("rst_pre_en1", {read_port_1_en, raddr_port_1}, {1'b1, 2'd0});
        #3;
        rst = 1;
        model_reset();
        #1;
        chk("rst_async_outputs", {desc_ready, uread_en, read_port_1_en, read_port_2_en,
            read_port_3_en, raddr_port_1, free_valid, free_idx, active_ports}, 0);
        tick(); tick();
        rst = 0;
        tick(); tick(); tick();
        chk("rst_refetch", {read_port_1_en, raddr_port_1, desc_ready}, {1'b1, 2'd1, 1'b1});

        // Simultaneous dones on ports 1 and 3 after reset (pointer at port 1)
        set_dest(3, 200);
        push(3);
        repeat (5) tick();
        chk("sim_en3", {read_port_3_en, raddr_port_3}, {1'b1, 2'd3});
        free_ready = 1;
        read_port_1_done = 1; read_port_3_done = 1;
        tick();
        chk("sim_first", {free_valid, free_idx}, {1'b1, 2'd1});
        tick();
        chk("sim_second", {free_valid, free_idx}, {1'b1, 2'd3});
        tick();
        chk("sim_empty", free_valid, 0);

        // Spurious done on an idle port
        read_port_3_done = 1;
        tick();
        chk("spur_idle", {free_valid, read_port_3_en, active_ports}, 0);
        tick();
        chk("spur_idle2", free_valid, 0);

        // Randomized traffic
        for (int b = 0; b < 15; b++) begin
            int guard;
            for (int s = 0; s < 4; s++) set_dest(s, pick_dest());
            auto_mode = 1;
            repeat (80) tick();
            auto_mode = 0;
            guard = 0;
            while (!(q.size() == 0 && m_t == 0 && m_en == 0 && m_pend == 0) && guard < 400) begin
                guard++;
                read_port_1_done = read_port_1_en;
                read_port_2_done = read_port_2_en;
                read_port_3_done = read_port_3_en;
                free_ready = ($urandom % 3 != 0);
                tick();
            end
            chk("drain_bounded", guard < 400, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/port_dispatch_sched.md
Name: port_dispatch_sched

Overview:
- Scheduler between the router's descriptor queue and its three output read ports.
- Takes slot-index descriptors one at a time, reads each slot's destination-ID field from the unit payload memory, and classifies it to port 1/2/3 by range.
- Issues the read enable and address to the selected port when that port is free, then returns the slot index to the free list once the port reports done.
- Multiple ports run concurrently; the descriptor queue is strictly in-order, so the head blocks until its port is free.

Parameters:
- UWIDTH, 8, payload word width and dest_id width.
- PTR_SZ, 2, slot index width.
- PTR_IN_SZ, 4, intra-slot word address width.
- DEST_FIELD, 1, intra-slot word offset holding dest_id.
- PORT2_LO, 128, lowest dest_id routed to port 2.
- PORT3_LO, 196, lowest dest_id routed to port 3.

Ports:
- clk2  in  1  sole clock.
- rst  in  1  reset, asynchronous, active-high.
- desc_valid  in  1  head descriptor present.
- desc_idx  in  PTR_SZ  head slot index; stable while desc_valid is high.
- desc_ready  out  1  one-cycle pop pulse, asserted when the head is issued.
- uread_en  out  1  payload read strobe.
- uaddr  out  PTR_SZ  payload slot address.
- uaddr_in  out  PTR_IN_SZ  payload word address.
- udata  in  UWIDTH  payload read data; valid one cycle after uread_en.
- read_port_1_en, read_port_2_en, read_port_3_en  out  1 each  port busy/enable; held high until that port's done.
- raddr_port_1, raddr_port_2, raddr_port_3  out  PTR_SZ each  slot index for the port; stable while its enable is high.
- read_port_1_done, read_port_2_done, read_port_3_done  in  1 each  single-cycle completion pulse.
- free_valid  out  1  freed slot index available.
- free_idx  out  PTR_SZ  freed slot index.
- free_ready  in  1  free-list accepts the index.
- active_ports  out  2  number of enables currently high (0..3).

Behaviour:
- All outputs are registered.
- Reset values: every output 0. FSM state is IDLE. ret_pend[3:1] = 0. Round-robin pointer = port 1.
- Destination classification (unsigned, UWIDTH wide):
  - dest_id < PORT2_LO → port 1.
  - PORT2_LO ≤ dest_id < PORT3_LO → port 2.
  - dest_id ≥ PORT3_LO → port 3.
- Port p is unavailable while read_port_p_en = 1 or ret_pend[p] = 1.
- FSM states: IDLE, FETCH, CLASSIFY, HOLD.
  - IDLE: if desc_valid, go to FETCH. In the next cycle uread_en = 1, uaddr = desc_idx, uaddr_in = DEST_FIELD.
  - FETCH: uread_en returns to 0 next cycle; go to CLASSIFY.
  - CLASSIFY: latch dest_id = udata and compute p.
    - If p is available: next cycle read_port_p_en = 1, raddr_port_p = desc_idx, desc_ready = 1 (one cycle); go to IDLE.
    - If p is unavailable: go to HOLD.
  - HOLD: re-evaluate availability of the latched p every cycle. When p becomes available, issue exactly as in CLASSIFY and go to IDLE. The payload is not re-read.
- Latency: desc_valid high in IDLE at cycle 0 → read_port_p_en and desc_ready high at cycle 3. Back-to-back issue interval is at least 4 cycles.
- Availability in CLASSIFY/HOLD uses the registered state. A done pulse in the same cycle does not free the port until the following cycle.
- Done handling: read_port_p_done is honoured only while read_port_p_en = 1; otherwise it is ignored (no state change). When honoured:
  - read_port_p_en clears next cycle.
  - ret_idx[p] = raddr_port_p and ret_pend[p] = 1.
  - raddr_port_p retains its value.
- Free return:
  - free_valid = 1 whenever any ret_pend bit is set.
  - The source is chosen round-robin starting at the pointer: the first pending port in order p, p+1, … with wrap 3 → 1.
  - The selection and free_idx are frozen while free_valid = 1 and free_ready = 0.
  - On free_valid && free_ready: clear ret_pend for the served port and move the pointer to the port after it. A new selection is presented the next cycle, so at most one return per cycle.
- Simultaneous dones on multiple ports are all captured in the same cycle and drained over successive cycles.
- active_ports equals the popcount of the three enables, updated the same cycle as the enables.
- Reset mid-operation:
  - All state clears immediately; enables drop and pending returns are discarded.
  - A descriptor fetched but not yet popped stays at the queue head, since desc_ready was never pulsed.

Test Plan:
- Single dispatch: desc_idx = 2, udata = 100 → cycle 3: read_port_1_en = 1, raddr_port_1 = 2, desc_ready pulse; done_1 → en clears, free_valid = 1, free_idx = 2.
- Classification boundaries: dest 127/128/195/196/255 → ports 1/2/2/3/3. Three concurrent enables give active_ports = 3.
- Head-of-line blocking: port 2 busy with idx 0, next descriptor idx 1 with dest 150 → FSM holds, desc_ready stays 0. done_2 with free_ready = 0 keeps port 2 unavailable; free_ready = 1 → port 2 is issued idx 1 one cycle after the return.
- Simultaneous dones on ports 1 and 3 with free_ready = 1 → free_idx returns the port 1 index then the port 3 index on consecutive cycles. free_ready = 0 holds free_idx stable.
- Spurious done_3 while read_port_3_en = 0 → no free_valid and no state change.
- rst asserted in HOLD with port 1 busy → all outputs 0 asynchronously. After release, the held descriptor is refetched from IDLE.
